// File: rtl/unidade_controle_if.sv
// Control-unit <-> datapath signal bundle: status flags in, counter/register strobes out.
// master = control unit side, slave = datapath/top-level side.
interface unidade_controle_if;
    logic       iniciar;
    logic       jogada_feita;
    logic       chavesIgualMemoria;
    logic       enderecoIgualLimite;
    logic       fimL;
    logic       timeout;

    logic       zeraR;
    logic       registraR;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraT;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualLimite, fimL, timeout,
        output zeraR, registraR, zeraE, contaE, zeraL, contaL, zeraT,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualLimite, fimL, timeout,
        input  zeraR, registraR, zeraE, contaE, zeraL, contaL, zeraT,
               pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle.sv
// Moore control FSM for the memory-sequence game; optional timeout loss via UC_TIMEOUT_EN.
// Latency: outputs decode from the state register only, one state per clock edge.
// Backpressure: none; espera_jogada simply holds until a play (or timeout) arrives.
module unidade_controle (
    input  logic                   clock,
    input  logic                   reset_n,
    unidade_controle_if.master     bus
);

`ifdef UC_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        INICIAL        = 4'b0000,
        PREPARACAO     = 4'b0001,
        INICIO_RODADA  = 4'b0010,
        ESPERA_JOGADA  = 4'b0011,
        REGISTRA       = 4'b0100,
        COMPARACAO     = 4'b0101,
        PROXIMA_JOGADA = 4'b0110,
        PROXIMA_RODADA = 4'b0111,
        FIM_ACERTOU    = 4'b1010,
        FIM_ERROU      = 4'b1110,
        FIM_TIMEOUT    = 4'b1101
    } estado_t;

    estado_t estado;
    estado_t proximo;
    logic    zera_t;
    logic    por_timeout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= INICIAL;
        else          estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = bus.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIO_RODADA;
            INICIO_RODADA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play arriving together with timeout takes precedence.
                if (bus.jogada_feita)                   proximo = REGISTRA;
                else if (TIMEOUT_EN && bus.timeout)     proximo = FIM_TIMEOUT;
                else                                    proximo = ESPERA_JOGADA;
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!bus.chavesIgualMemoria)                    proximo = FIM_ERROU;
                else if (bus.enderecoIgualLimite && bus.fimL)   proximo = FIM_ACERTOU;
                else if (bus.enderecoIgualLimite)               proximo = PROXIMA_RODADA;
                else                                            proximo = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIO_RODADA;
            FIM_ACERTOU:    proximo = bus.iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      proximo = bus.iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:    proximo = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        proximo = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraR     = 1'b0;
        bus.registraR = 1'b0;
        bus.zeraE     = 1'b0;
        bus.contaE    = 1'b0;
        bus.zeraL     = 1'b0;
        bus.contaL    = 1'b0;
        bus.pronto    = 1'b0;
        bus.ganhou    = 1'b0;
        bus.perdeu    = 1'b0;
        zera_t        = 1'b0;
        por_timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                bus.zeraR = 1'b1;
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                zera_t    = 1'b1;
            end
            INICIO_RODADA: begin
                bus.zeraE = 1'b1;
                zera_t    = 1'b1;
            end
            REGISTRA:       bus.registraR = 1'b1;
            PROXIMA_JOGADA: begin
                bus.contaE = 1'b1;
                zera_t     = 1'b1;
            end
            PROXIMA_RODADA: bus.contaL = 1'b1;
            FIM_ACERTOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto  = 1'b1;
                bus.perdeu  = 1'b1;
                por_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    // Without the timeout feature the timer is never restarted and the loss cause is never flagged.
    assign bus.zeraT      = zera_t & TIMEOUT_EN;
    assign bus.db_timeout = por_timeout & TIMEOUT_EN;
    assign bus.db_estado  = estado;

endmodule
